// File: rtl/regfile_wb_sched_if.sv
// Bundle of the decode, write-back source and register-file signals around the scheduler.
// The scheduler attaches as slave; the pipeline around it attaches as master.
interface regfile_wb_sched_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            iss_valid;
  logic            iss_wen;
  logic [AW-1:0]   iss_rs1;
  logic [AW-1:0]   iss_rs2;
  logic [AW-1:0]   iss_rd;
  logic            iss_stall;
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            mem_valid;
  logic [AW-1:0]   mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            mem_ready;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            busy;
  logic            wb_err;

  modport master (
    output iss_valid, iss_wen, iss_rs1, iss_rs2, iss_rd,
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  iss_stall, alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, busy, wb_err
  );

  modport slave (
    input  iss_valid, iss_wen, iss_rs1, iss_rs2, iss_rd,
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output iss_stall, alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, busy, wb_err
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: round-robin ALU/load arbitration onto the single register-file
// write port, plus a pending-write scoreboard that decode uses to stall RAW/WAW hazards.
module regfile_wb_sched #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input logic               clk,
  input logic               rst,
  regfile_wb_sched_if.slave bus
);
  localparam int NREG = 2 ** AW;
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  logic [NREG-1:0] pending_q, pending_d;
  logic            rr_last_q, rr_last_d;
  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            busy_q;
  logic            wb_err_q, wb_err_d;

  logic            hazard, iss_accept;
  logic            gnt_alu, gnt_mem, gnt_any;
  logic [AW-1:0]   gnt_rd;
  logic [XLEN-1:0] gnt_data;

  // pending_q[0] is forced low, so x0 operands never produce a hazard.
  assign hazard     = pending_q[bus.iss_rs1] | pending_q[bus.iss_rs2]
                    | (bus.iss_wen & pending_q[bus.iss_rd]);
  assign iss_accept = bus.iss_valid & ~hazard;

  // Grants look only at the two valids and the round-robin pointer.
  assign gnt_alu  = bus.alu_valid & (~bus.mem_valid | (rr_last_q == SRC_MEM));
  assign gnt_mem  = bus.mem_valid & (~bus.alu_valid | (rr_last_q == SRC_ALU));
  assign gnt_any  = gnt_alu | gnt_mem;
  assign gnt_rd   = gnt_alu ? bus.alu_rd   : bus.mem_rd;
  assign gnt_data = gnt_alu ? bus.alu_data : bus.mem_data;

  always_comb begin
    pending_d  = pending_q;
    rr_last_d  = rr_last_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    wb_err_d   = wb_err_q;

    // Clear before set so a same-edge set of the same index wins.
    if (rf_we_q) pending_d[rf_waddr_q] = 1'b0;
    if (iss_accept && bus.iss_wen) pending_d[bus.iss_rd] = 1'b1;
    pending_d[0] = 1'b0;

    if (bus.alu_valid && bus.mem_valid) rr_last_d = gnt_alu ? SRC_ALU : SRC_MEM;

    if (gnt_any) begin
      rf_we_d    = (gnt_rd != '0);
      rf_waddr_d = gnt_rd;
      rf_wdata_d = gnt_data;
      if ((gnt_rd != '0) && !pending_q[gnt_rd]) wb_err_d = 1'b1;
    end
  end

  // Stage boundary: scoreboard, arbitration pointer and staged register-file write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      rr_last_q  <= SRC_MEM;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= 1'b0;
      wb_err_q   <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      rr_last_q  <= rr_last_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= |pending_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign bus.iss_stall = bus.iss_valid & hazard;
  assign bus.alu_ready = gnt_alu;
  assign bus.mem_ready = gnt_mem;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.busy      = busy_q;
  assign bus.wb_err    = wb_err_q;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: reset, RAW, contention, x0, WAW, error, async reset.
module tb_regfile_wb_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  regfile_wb_sched_if #(.XLEN(32), .AW(5)) bus ();

  regfile_wb_sched #(.XLEN(32), .AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iss_valid = 1'b0; bus.iss_wen = 1'b0;
    bus.iss_rs1 = '0; bus.iss_rs2 = '0; bus.iss_rd = '0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rd, input logic wen);
    bus.iss_valid = 1'b1; bus.iss_wen = wen;
    bus.iss_rs1 = rs1; bus.iss_rs2 = '0; bus.iss_rd = rd;
  endtask

  initial begin
    idle();
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_rf_we", bus.rf_we, 0);
    chk("rst_waddr", bus.rf_waddr, 0);
    chk("rst_wdata", bus.rf_wdata, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_wb_err", bus.wb_err, 0);
    tick();

    // RAW on x5
    issue(0, 5, 1); #1;
    chk("raw_c0_stall", bus.iss_stall, 0);
    tick();
    chk("raw_c1_busy", bus.busy, 1);
    issue(5, 0, 0); #1;
    chk("raw_c1_stall", bus.iss_stall, 1);
    tick();
    bus.alu_valid = 1'b1; bus.alu_rd = 5; bus.alu_data = 32'hDEADBEEF; #1;
    chk("raw_c2_stall", bus.iss_stall, 1);
    chk("raw_c2_alu_ready", bus.alu_ready, 1);
    tick();
    bus.alu_valid = 1'b0; #1;
    chk("raw_c3_rf_we", bus.rf_we, 1);
    chk("raw_c3_waddr", bus.rf_waddr, 5);
    chk("raw_c3_wdata", bus.rf_wdata, 32'hDEADBEEF);
    chk("raw_c3_stall", bus.iss_stall, 1);
    tick();
    chk("raw_c4_stall", bus.iss_stall, 0);
    chk("raw_c4_rf_we", bus.rf_we, 0);
    chk("raw_c4_busy", bus.busy, 0);
    idle();
    tick();

    // Contention: x1..x4 pending, then both sources valid for 4 cycles
    for (int r = 1; r <= 4; r++) begin
      issue(0, 5'(r), 1); #1;
      chk("cont_issue_stall", bus.iss_stall, 0);
      tick();
    end
    idle();
    chk("cont_busy", bus.busy, 1);
    bus.alu_valid = 1'b1; bus.alu_rd = 1; bus.alu_data = 32'h101;
    bus.mem_valid = 1'b1; bus.mem_rd = 2; bus.mem_data = 32'h102; #1;
    chk("cont_a_alu_ready", bus.alu_ready, 1);
    chk("cont_a_mem_ready", bus.mem_ready, 0);
    tick();
    bus.alu_rd = 3; bus.alu_data = 32'h103; #1;
    chk("cont_b_alu_ready", bus.alu_ready, 0);
    chk("cont_b_mem_ready", bus.mem_ready, 1);
    chk("cont_b_waddr", bus.rf_waddr, 1);
    chk("cont_b_wdata", bus.rf_wdata, 32'h101);
    tick();
    bus.mem_rd = 4; bus.mem_data = 32'h104; #1;
    chk("cont_c_alu_ready", bus.alu_ready, 1);
    chk("cont_c_mem_ready", bus.mem_ready, 0);
    chk("cont_c_waddr", bus.rf_waddr, 2);
    chk("cont_c_wdata", bus.rf_wdata, 32'h102);
    tick();
    bus.alu_rd = 0; bus.alu_data = 32'h0; #1;
    chk("cont_d_alu_ready", bus.alu_ready, 0);
    chk("cont_d_mem_ready", bus.mem_ready, 1);
    chk("cont_d_waddr", bus.rf_waddr, 3);
    chk("cont_d_wdata", bus.rf_wdata, 32'h103);
    tick();
    idle(); #1;
    chk("cont_e_rf_we", bus.rf_we, 1);
    chk("cont_e_waddr", bus.rf_waddr, 4);
    chk("cont_e_wdata", bus.rf_wdata, 32'h104);
    tick();
    chk("cont_f_rf_we", bus.rf_we, 0);
    chk("cont_f_busy", bus.busy, 0);
    chk("cont_f_wb_err", bus.wb_err, 0);

    // x0 handling
    issue(0, 0, 1); #1;
    chk("x0_issue_stall", bus.iss_stall, 0);
    tick();
    idle();
    chk("x0_busy", bus.busy, 0);
    bus.mem_valid = 1'b1; bus.mem_rd = 0; bus.mem_data = 32'h55; #1;
    chk("x0_mem_ready", bus.mem_ready, 1);
    tick();
    idle(); #1;
    chk("x0_rf_we", bus.rf_we, 0);
    chk("x0_wb_err", bus.wb_err, 0);
    tick();

    // WAW on x7
    issue(0, 7, 1); #1;
    chk("waw_c0_stall", bus.iss_stall, 0);
    tick();
    #1;
    chk("waw_c1_stall", bus.iss_stall, 1);
    tick();
    bus.alu_valid = 1'b1; bus.alu_rd = 7; bus.alu_data = 32'h77; #1;
    chk("waw_c2_stall", bus.iss_stall, 1);
    tick();
    bus.alu_valid = 1'b0; #1;
    chk("waw_c3_stall", bus.iss_stall, 1);
    chk("waw_c3_waddr", bus.rf_waddr, 7);
    chk("waw_c3_rf_we", bus.rf_we, 1);
    tick();
    #1;
    chk("waw_c4_stall", bus.iss_stall, 0);
    tick();
    idle();
    chk("waw_busy_again", bus.busy, 1);
    bus.alu_valid = 1'b1; bus.alu_rd = 7; bus.alu_data = 32'h78;
    tick();
    idle();
    tick(); tick();
    chk("waw_drained_busy", bus.busy, 0);
    chk("waw_wb_err", bus.wb_err, 0);

    // Write-back with nothing pending
    bus.alu_valid = 1'b1; bus.alu_rd = 9; bus.alu_data = 32'h99; #1;
    chk("err_alu_ready", bus.alu_ready, 1);
    tick();
    idle(); #1;
    chk("err_rf_we", bus.rf_we, 1);
    chk("err_waddr", bus.rf_waddr, 9);
    chk("err_wb_err", bus.wb_err, 1);
    tick(); tick();
    chk("err_sticky", bus.wb_err, 1);

    // Async reset while x5 write is staged
    issue(0, 5, 1);
    tick();
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5; bus.alu_data = 32'h1234;
    tick();
    idle(); #1;
    chk("mid_pre_rf_we", bus.rf_we, 1);
    chk("mid_pre_busy", bus.busy, 1);
    issue(5, 0, 0); #1;
    chk("mid_pre_stall", bus.iss_stall, 1);
    #1 rst = 1'b1; #1;
    chk("mid_rst_rf_we", bus.rf_we, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_stall", bus.iss_stall, 0);
    chk("mid_rst_wb_err", bus.wb_err, 0);
    tick();
    rst = 1'b0;
    idle();
    tick();
    chk("post_rst_rf_we", bus.rf_we, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
